// File: rtl/board_memory_pkg.sv
// board_memory_pkg
//   Shared definitions for the board tile store: default geometry, the
//   search FSM state encoding and the ring select codes.
package board_memory_pkg;

  localparam int N_EDGE_DEF   = 24;
  localparam int N_CENTER_DEF = 12;
  localparam int DATA_W_DEF   = 4;
  localparam int ADDR_W_DEF   = 6;

  localparam logic RING_EDGE   = 1'b0;
  localparam logic RING_CENTER = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } find_state_t;

endpackage

// File: rtl/board_memory_ring_next.sv
// ring_next
//   Wrapped increment of a ring position: next = (ptr == size-1) ? 0 : ptr+1.
//   Shared with the game move logic.
// Ports
//   ptr   in   ADDR_W  current ring-relative position
//   size  in   ADDR_W  number of tiles in the ring
//   next  out  ADDR_W  following position, wrapping to 0
module ring_next #(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [ADDR_W-1:0] size,
  output logic [ADDR_W-1:0] next
);

  assign next = (ptr == size - ADDR_W'(1)) ? '0 : ptr + ADDR_W'(1);

endmodule

// File: rtl/board_memory.sv
// board_memory
//   Tile store for the game board (edge ring + centre ring) with bulk load,
//   single-tile write, combinational read and a circular search engine that
//   finds the next tile equal to a key within one ring.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   WR, EDGE_DATA_IN,
//   CENTER_DATA_IN               bulk load of every tile (tile 0 in the MSBs)
//   WE_ONE, WR_ADDR, WR_DATA     single-tile write (out-of-range ignored, WR wins)
//   ADDR, DATA_OUT               combinational read, 0 when out of range
//   FIND_START/RING/FROM/KEY     search request, sampled only in IDLE
//   FIND_BUSY/DONE/HIT/IDX       search status and result
//
// state  | meaning
// S_IDLE | waiting for FIND_START
// S_SCAN | comparing one candidate per cycle, FIND_BUSY high
// S_DONE | one-cycle FIND_DONE pulse, FIND_START ignored
module board_memory
  import board_memory_pkg::*;
#(
  parameter int N_EDGE   = N_EDGE_DEF,
  parameter int N_CENTER = N_CENTER_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       WR,
  input  logic [N_EDGE*DATA_W-1:0]   EDGE_DATA_IN,
  input  logic [N_CENTER*DATA_W-1:0] CENTER_DATA_IN,
  input  logic                       WE_ONE,
  input  logic [ADDR_W-1:0]          WR_ADDR,
  input  logic [DATA_W-1:0]          WR_DATA,
  input  logic [ADDR_W-1:0]          ADDR,
  output logic [DATA_W-1:0]          DATA_OUT,
  input  logic                       FIND_START,
  input  logic                       FIND_RING,
  input  logic [ADDR_W-1:0]          FIND_FROM,
  input  logic [DATA_W-1:0]          FIND_KEY,
  output logic                       FIND_BUSY,
  output logic                       FIND_DONE,
  output logic                       FIND_HIT,
  output logic [ADDR_W-1:0]          FIND_IDX
);

  localparam int N_TOTAL = N_EDGE + N_CENTER;
  localparam logic [ADDR_W-1:0] SIZE_EDGE   = ADDR_W'(N_EDGE);
  localparam logic [ADDR_W-1:0] SIZE_CENTER = ADDR_W'(N_CENTER);

  logic [DATA_W-1:0] mem [N_TOTAL];

  find_state_t       state;
  logic              ring_q;
  logic [DATA_W-1:0] key_q;
  logic [ADDR_W-1:0] from_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;

  logic              ring_sel;
  logic [ADDR_W-1:0] ring_size;
  logic [ADDR_W-1:0] ptr_src;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W-1:0] scan_addr;

  // In IDLE the ring and start point come straight from the request; during
  // SCAN they come from the latched copy and the running pointer.
  assign ring_sel  = (state == S_IDLE) ? FIND_RING : ring_q;
  assign ring_size = (ring_sel == RING_CENTER) ? SIZE_CENTER : SIZE_EDGE;
  assign ptr_src   = (state == S_IDLE) ? FIND_FROM : ptr;
  assign scan_addr = ((ring_q == RING_CENTER) ? SIZE_EDGE : '0) + ptr;

  ring_next #(.ADDR_W(ADDR_W)) u_ring_next (
    .ptr  (ptr_src),
    .size (ring_size),
    .next (ptr_next)
  );

  assign DATA_OUT = (int'(ADDR) < N_TOTAL) ? mem[ADDR] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TOTAL; k++) mem[k] <= '0;
    end else if (WR) begin
      for (int k = 0; k < N_EDGE; k++)
        mem[k] <= EDGE_DATA_IN[(N_EDGE-k)*DATA_W-1 -: DATA_W];
      for (int k = 0; k < N_CENTER; k++)
        mem[N_EDGE+k] <= CENTER_DATA_IN[(N_CENTER-k)*DATA_W-1 -: DATA_W];
    end else if (WE_ONE && (int'(WR_ADDR) < N_TOTAL)) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ring_q    <= RING_EDGE;
      key_q     <= '0;
      from_q    <= '0;
      ptr       <= '0;
      cnt       <= '0;
      FIND_BUSY <= 1'b0;
      FIND_DONE <= 1'b0;
      FIND_HIT  <= 1'b0;
      FIND_IDX  <= '0;
    end else begin
      FIND_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (FIND_START) begin
            ring_q <= FIND_RING;
            key_q  <= FIND_KEY;
            from_q <= FIND_FROM;
            if (FIND_FROM < ring_size) begin
              ptr       <= ptr_next;
              cnt       <= '0;
              FIND_BUSY <= 1'b1;
              state     <= S_SCAN;
            end else begin
              FIND_HIT  <= 1'b0;
              FIND_IDX  <= FIND_FROM;
              FIND_DONE <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SCAN: begin
          if (WR) begin
            // bulk reload invalidates the search; results keep their old values
            FIND_BUSY <= 1'b0;
            state     <= S_IDLE;
          end else if (mem[scan_addr] == key_q) begin
            FIND_HIT  <= 1'b1;
            FIND_IDX  <= ptr;
            FIND_BUSY <= 1'b0;
            FIND_DONE <= 1'b1;
            state     <= S_DONE;
          end else if (cnt == ring_size - ADDR_W'(1)) begin
            // wrapped all the way round back to FIND_FROM
            FIND_HIT  <= 1'b0;
            FIND_IDX  <= from_q;
            FIND_BUSY <= 1'b0;
            FIND_DONE <= 1'b1;
            state     <= S_DONE;
          end else begin
            ptr <= ptr_next;
            cnt <= cnt + ADDR_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_memory.sv
module tb_board_memory;
  localparam int N_EDGE   = 24;
  localparam int N_CENTER = 12;
  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 6;
  localparam int N_TOTAL  = N_EDGE + N_CENTER;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       WR;
  logic [N_EDGE*DATA_W-1:0]   EDGE_DATA_IN;
  logic [N_CENTER*DATA_W-1:0] CENTER_DATA_IN;
  logic                       WE_ONE;
  logic [ADDR_W-1:0]          WR_ADDR;
  logic [DATA_W-1:0]          WR_DATA;
  logic [ADDR_W-1:0]          ADDR;
  logic [DATA_W-1:0]          DATA_OUT;
  logic                       FIND_START;
  logic                       FIND_RING;
  logic [ADDR_W-1:0]          FIND_FROM;
  logic [DATA_W-1:0]          FIND_KEY;
  logic                       FIND_BUSY;
  logic                       FIND_DONE;
  logic                       FIND_HIT;
  logic [ADDR_W-1:0]          FIND_IDX;

  board_memory #(.N_EDGE(N_EDGE), .N_CENTER(N_CENTER), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .WR(WR), .EDGE_DATA_IN(EDGE_DATA_IN), .CENTER_DATA_IN(CENTER_DATA_IN),
    .WE_ONE(WE_ONE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .ADDR(ADDR), .DATA_OUT(DATA_OUT),
    .FIND_START(FIND_START), .FIND_RING(FIND_RING), .FIND_FROM(FIND_FROM), .FIND_KEY(FIND_KEY),
    .FIND_BUSY(FIND_BUSY), .FIND_DONE(FIND_DONE), .FIND_HIT(FIND_HIT), .FIND_IDX(FIND_IDX)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem [N_TOTAL];
  bit   m_busy = 0, m_done = 0, m_hit = 0;
  int   m_idx = 0;
  int   m_cand[$];
  int   m_base = 0, m_from = 0;
  logic [DATA_W-1:0] m_key = '0;

  initial foreach (m_mem[i]) m_mem[i] = '0;

  always @(posedge clk) begin : model
    bit nd;
    int c;
    int r;
    nd = 0;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_busy = 0; m_hit = 0; m_idx = 0;
      m_cand.delete();
    end else begin
      if (m_busy) begin
        if (WR) begin
          m_busy = 0;
          m_cand.delete();
        end else begin
          c = m_cand.pop_front();
          if (m_mem[m_base + c] == m_key) begin
            m_hit = 1; m_idx = c; m_busy = 0; nd = 1;
            m_cand.delete();
          end else if (m_cand.size() == 0) begin
            m_hit = 0; m_idx = m_from; m_busy = 0; nd = 1;
          end
        end
      end else if (!m_done && FIND_START) begin
        r      = FIND_RING ? N_CENTER : N_EDGE;
        m_base = FIND_RING ? N_EDGE : 0;
        m_key  = FIND_KEY;
        m_from = int'(FIND_FROM);
        if (m_from < r) begin
          for (int j = 1; j <= r; j++) m_cand.push_back((m_from + j) % r);
          m_busy = 1;
        end else begin
          m_hit = 0; m_idx = m_from; nd = 1;
        end
      end
      if (WR) begin
        for (int k = 0; k < N_EDGE; k++)   m_mem[k] = EDGE_DATA_IN[(N_EDGE-k)*DATA_W-1 -: DATA_W];
        for (int k = 0; k < N_CENTER; k++) m_mem[N_EDGE+k] = CENTER_DATA_IN[(N_CENTER-k)*DATA_W-1 -: DATA_W];
      end else if (WE_ONE && int'(WR_ADDR) < N_TOTAL) begin
        m_mem[WR_ADDR] = WR_DATA;
      end
    end
    m_done = nd;
  end

  function automatic int exp_dout();
    return (int'(ADDR) < N_TOTAL) ? int'(m_mem[ADDR]) : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out", int'(DATA_OUT), exp_dout());
      chk("busy", int'(FIND_BUSY), int'(m_busy));
      chk("done", int'(FIND_DONE), int'(m_done));
      chk("hit", int'(FIND_HIT), int'(m_hit));
      chk("idx", int'(FIND_IDX), m_idx);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [DATA_W-1:0] tiles [N_TOTAL];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_tiles();
    foreach (tiles[i]) tiles[i] = '0;
  endtask

  task automatic load_tiles();
    for (int k = 0; k < N_EDGE; k++)   EDGE_DATA_IN[(N_EDGE-1-k)*DATA_W +: DATA_W] = tiles[k];
    for (int k = 0; k < N_CENTER; k++) CENTER_DATA_IN[(N_CENTER-1-k)*DATA_W +: DATA_W] = tiles[N_EDGE+k];
    WR = 1;
    tick();
    WR = 0;
  endtask

  task automatic read_at(input int a, input int exp, input string name);
    ADDR = ADDR_W'(a);
    @(negedge clk);
    chk(name, int'(DATA_OUT), exp);
    tick();
  endtask

  // inj: 0 none, 1 WE_ONE(a,d), 2 re-START with other key, 3 WR abort, 4 rst
  task automatic run_find(input string name, input bit ring, input int from, input int key,
                          input int exp_lat, input int exp_busy, input int exp_hit, input int exp_idx,
                          input int inj, input int inj_cyc, input int inj_a, input int inj_d);
    int busy_n;
    int got;
    int limit;
    bit seen;
    busy_n = 0; got = 0; seen = 0;
    limit = (exp_lat < 0) ? 30 : exp_lat + 5;
    tick();
    FIND_RING  = ring;
    FIND_FROM  = ADDR_W'(from);
    FIND_KEY   = DATA_W'(key);
    FIND_START = 1;
    tick();
    FIND_START = 0;
    for (int lat = 1; lat <= limit; lat++) begin
      @(negedge clk);
      if (FIND_BUSY) busy_n++;
      if (FIND_DONE) begin
        seen = 1; got = lat;
        break;
      end
      if (lat == inj_cyc) begin
        case (inj)
          1: begin WE_ONE = 1; WR_ADDR = ADDR_W'(inj_a); WR_DATA = DATA_W'(inj_d); end
          2: begin FIND_START = 1; FIND_KEY = DATA_W'(key ^ 1); end
          3: WR = 1;
          4: rst = 1;
          default: ;
        endcase
      end
      tick();
      WE_ONE = 0; WR = 0; rst = 0; FIND_START = 0; FIND_KEY = DATA_W'(key);
    end
    if (exp_lat < 0) chk({name, "_no_done"}, int'(seen), 0);
    else             chk({name, "_latency"}, got, exp_lat);
    chk({name, "_busy_cycles"}, busy_n, exp_busy);
    chk({name, "_hit"}, int'(FIND_HIT), exp_hit);
    chk({name, "_idx"}, int'(FIND_IDX), exp_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; WR = 0; WE_ONE = 0; WR_ADDR = '0; WR_DATA = '0; ADDR = '0;
    EDGE_DATA_IN = '0; CENTER_DATA_IN = '0;
    FIND_START = 0; FIND_RING = 0; FIND_FROM = '0; FIND_KEY = '0;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_busy", int'(FIND_BUSY), 0);
    chk("reset_hit", int'(FIND_HIT), 0);
    chk("reset_idx", int'(FIND_IDX), 0);
    chk("reset_data", int'(DATA_OUT), 0);
    tick();

    // 1: bulk load tile k = k % 16 and read back
    foreach (tiles[i]) tiles[i] = DATA_W'(i % 16);
    load_tiles();
    read_at(0, 0, "rd_addr0");
    read_at(1, 1, "rd_addr1");
    read_at(23, 7, "rd_addr23");
    read_at(24, 8, "rd_addr24");
    read_at(35, 3, "rd_addr35");
    read_at(40, 0, "rd_addr40");

    // 2: tile 3 = 5 only, search edge from 0
    clear_tiles(); tiles[3] = 4'd5; load_tiles();
    ADDR = 6'd3;
    run_find("edge_hit", 0, 0, 5, 4, 3, 1, 3, 0, 0, 0, 0);

    // 3: wrap-around hit and full miss
    clear_tiles(); tiles[1] = 4'd9; load_tiles();
    run_find("wrap_hit", 0, 20, 9, 6, 5, 1, 1, 0, 0, 0, 0);
    run_find("full_miss", 0, 20, 3, 25, 24, 0, 20, 0, 0, 0, 0);

    // 4: centre ring wrap and out-of-range start
    clear_tiles(); tiles[24] = 4'd7; load_tiles();
    run_find("ctr_wrap", 1, 11, 7, 2, 1, 1, 0, 0, 0, 0, 0);
    run_find("ctr_bad_from", 1, 12, 7, 1, 0, 0, 12, 0, 0, 0, 0);
    // START while in DONE must be ignored
    FIND_RING = 0; FIND_FROM = '0; FIND_KEY = '0; FIND_START = 1;
    tick();
    FIND_START = 0;
    @(negedge clk);
    chk("start_in_done_ignored", int'(FIND_BUSY), 0);
    tick();

    // 5: WR beats WE_ONE, WR abort, rst abort
    foreach (tiles[i]) tiles[i] = 4'd4;
    WE_ONE = 1; WR_ADDR = 6'd5; WR_DATA = 4'hF;
    load_tiles();
    WE_ONE = 0;
    read_at(5, 4, "wr_beats_we_one");
    run_find("wr_abort", 0, 0, 9, -1, 2, 0, 12, 3, 2, 0, 0);
    run_find("hit_before_rst", 0, 0, 4, 2, 1, 1, 1, 0, 0, 0, 0);
    run_find("rst_abort", 0, 0, 9, -1, 2, 0, 0, 4, 2, 0, 0);
    read_at(5, 0, "mem_cleared_by_rst");

    // 6: write ahead of the pointer during SCAN, START while busy
    ADDR = 6'd10;
    run_find("we_ahead", 0, 0, 6, 11, 10, 1, 10, 1, 2, 10, 6);
    run_find("start_while_busy", 0, 0, 6, 11, 10, 1, 10, 2, 1, 0, 0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
